sprite_pixel_fetch: RTL and testbench

Downstream of the per-sprite matchers in the GPU pixel path. Each `gpu_clk` it:
- takes the match, tile number and x/y offsets from NUM_SPRITES matchers;
- selects the highest-priority sprite that matches;
- fetches that sprite's texel from a synchronous tile memory;
- outputs either the sprite colour or the background colour, two cycles later, aligned with a delayed valid.

It also raises a per-line collision flag for the CPU-facing status logic.

---
 rtl/sprite_pixel_fetch_pkg.sv | 18 +
 rtl/sprite_priority_enc.sv | 25 ++
 rtl/sprite_pixel_fetch.sv | 132 +++++++++++++
 tb/tb_sprite_pixel_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pixel_fetch_pkg.sv
// Shared GPU sprite definitions: colour width, the disabled-tile marker and the
// tile-memory address packing used by both the pixel fetch and the CPU tile writer.
package sprite_pixel_fetch_pkg;

  localparam int          COLOR_W       = 12;
  localparam logic [15:0] TILE_DISABLED = 16'hFFFF;
  localparam int          FULL_ADDR_W   = 24;

  // Full-width {tile, y, x}; callers keep the low TILE_BITS+8 bits, which wraps the tile number.
  function automatic logic [FULL_ADDR_W-1:0] pack_tile_addr(
    input logic [15:0] tile,
    input logic [3:0]  y,
    input logic [3:0]  x
  );
    return {tile, y, x};
  endfunction

endpackage

// File: rtl/sprite_priority_enc.sv
// Combinational priority encoder over sprite enables; index 0 wins.
// Also reports whether two or more enables are set.
module sprite_priority_enc #(
  parameter int N     = 4,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     en,
  output logic [SEL_W-1:0] sel,
  output logic             hit,
  output logic             multi
);

  // Ascending scan: first enabled index is kept, any later enable flags multiple hits.
  always_comb begin
    sel   = {SEL_W{1'b0}};
    hit   = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      multi = multi | (hit & en[i]);
      sel   = (en[i] && !hit) ? SEL_W'(i) : sel;
      hit   = hit | en[i];
    end
  end

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: picks the highest-priority matching sprite, reads its texel
// from synchronous tile memory and emits sprite or background colour two cycles later.
module sprite_pixel_fetch #(
  parameter int                        NUM_SPRITES = 4,
  parameter int                        COLOR_W     = sprite_pixel_fetch_pkg::COLOR_W,
  parameter int                        TILE_BITS   = 8,
  parameter logic [COLOR_W-1:0]        TRANSPARENT = {COLOR_W{1'b0}}
) (
  input  logic                         gpu_clk,
  input  logic                         reset,
  input  logic                         pixel_valid,
  input  logic                         line_start,
  input  logic [NUM_SPRITES-1:0]       match,
  input  logic [16*NUM_SPRITES-1:0]    tile_number,
  input  logic [8*NUM_SPRITES-1:0]     x_offset,
  input  logic [8*NUM_SPRITES-1:0]     y_offset,
  input  logic [COLOR_W-1:0]           bg_color,
  output logic                         tile_rd_en,
  output logic [TILE_BITS+7:0]         tile_addr,
  input  logic [COLOR_W-1:0]           tile_data,
  output logic [COLOR_W-1:0]           color,
  output logic                         color_valid,
  output logic                         collision
);

  import sprite_pixel_fetch_pkg::*;

  localparam int SEL_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int ADDR_W = TILE_BITS + 8;

  logic [NUM_SPRITES-1:0]   en_s;
  logic [SEL_W-1:0]         sel_s;
  logic                     hit_s;
  logic                     multi_s;
  logic [15:0]              tile_sel_s;
  logic [7:0]               x_sel_s;
  logic [7:0]               y_sel_s;
  logic [FULL_ADDR_W-1:0]   full_addr_s;
  logic [ADDR_W-1:0]        addr_nxt_s;
  logic                     unused_bits_s;

  logic                     tile_rd_en_r;
  logic [ADDR_W-1:0]        tile_addr_r;
  logic                     valid1_r;
  logic                     hit1_r;
  logic [COLOR_W-1:0]       bg1_r;
  logic                     valid2_r;
  logic                     hit2_r;
  logic [COLOR_W-1:0]       bg2_r;
  logic                     collision_r;
  logic [COLOR_W-1:0]       color_s;

  // A sprite whose matcher still holds the disabled tile never takes part.
  always_comb begin
    en_s = {NUM_SPRITES{1'b0}};
    for (int i = 0; i < NUM_SPRITES; i++) begin
      en_s[i] = match[i] & (tile_number[16*i +: 16] != TILE_DISABLED);
    end
  end

  sprite_priority_enc #(
    .N     (NUM_SPRITES),
    .SEL_W (SEL_W)
  ) u_prio (
    .en    (en_s),
    .sel   (sel_s),
    .hit   (hit_s),
    .multi (multi_s)
  );

  // Build the selected sprite's texel address; offsets and tile number are truncated.
  always_comb begin
    tile_sel_s  = tile_number[16*int'(sel_s) +: 16];
    x_sel_s     = x_offset[8*int'(sel_s) +: 8];
    y_sel_s     = y_offset[8*int'(sel_s) +: 8];
    full_addr_s = pack_tile_addr(tile_sel_s, y_sel_s[3:0], x_sel_s[3:0]);
    addr_nxt_s  = hit_s ? full_addr_s[ADDR_W-1:0] : {ADDR_W{1'b0}};
  end

  assign unused_bits_s = ^{x_sel_s[7:4], y_sel_s[7:4], full_addr_s};

  // Fetch stage, two-deep pixel side-band pipeline and per-line collision flag.
  always_ff @(posedge gpu_clk) begin
    if (reset) begin
      tile_rd_en_r <= 1'b0;
      tile_addr_r  <= {ADDR_W{1'b0}};
      valid1_r     <= 1'b0;
      hit1_r       <= 1'b0;
      bg1_r        <= {COLOR_W{1'b0}};
      valid2_r     <= 1'b0;
      hit2_r       <= 1'b0;
      bg2_r        <= {COLOR_W{1'b0}};
      collision_r  <= 1'b0;
    end else begin
      tile_rd_en_r <= pixel_valid & hit_s;
      tile_addr_r  <= addr_nxt_s;
      valid1_r     <= pixel_valid;
      hit1_r       <= hit_s;
      bg1_r        <= bg_color;
      valid2_r     <= valid1_r;
      hit2_r       <= hit1_r;
      bg2_r        <= bg1_r;
      // A new overlap beats the line-start clear arriving in the same cycle.
      if (pixel_valid && multi_s) begin
        collision_r <= 1'b1;
      end else if (line_start) begin
        collision_r <= 1'b0;
      end else begin
        collision_r <= collision_r;
      end
    end
  end

  // Texel arrives this cycle; a transparent top sprite shows background, not lower sprites.
  always_comb begin
    color_s = {COLOR_W{1'b0}};
    if (!valid2_r) begin
      color_s = {COLOR_W{1'b0}};
    end else if (hit2_r && (tile_data != TRANSPARENT)) begin
      color_s = tile_data;
    end else begin
      color_s = bg2_r;
    end
  end

  assign tile_rd_en  = tile_rd_en_r;
  assign tile_addr   = tile_addr_r;
  assign color       = color_s;
  assign color_valid = valid2_r;
  assign collision   = collision_r;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Randomised self-checking bench for sprite_pixel_fetch: a per-pixel reference model
// fills expectation slots indexed by cycle, and a negedge process compares against them.
module tb_sprite_pixel_fetch;

  localparam int MAXC = 4096;

  logic         gpu_clk;
  logic         reset;
  logic         pixel_valid;
  logic         line_start;
  logic [3:0]   match;
  logic [63:0]  tile_number;
  logic [31:0]  x_offset;
  logic [31:0]  y_offset;
  logic [11:0]  bg_color;
  logic         tile_rd_en;
  logic [15:0]  tile_addr;
  logic [11:0]  tile_data;
  logic [11:0]  color;
  logic         color_valid;
  logic         collision;

  logic [11:0]  mem [0:65535];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic coll_m = 1'b0;

  bit          k_s0  [MAXC];
  bit          k_col [MAXC];
  logic        e_rd  [MAXC];
  logic [15:0] e_addr[MAXC];
  logic        e_coll[MAXC];
  logic        e_cv  [MAXC];
  logic [11:0] e_col [MAXC];

  sprite_pixel_fetch dut (
    .gpu_clk     (gpu_clk),
    .reset       (reset),
    .pixel_valid (pixel_valid),
    .line_start  (line_start),
    .match       (match),
    .tile_number (tile_number),
    .x_offset    (x_offset),
    .y_offset    (y_offset),
    .bg_color    (bg_color),
    .tile_rd_en  (tile_rd_en),
    .tile_addr   (tile_addr),
    .tile_data   (tile_data),
    .color       (color),
    .color_valid (color_valid),
    .collision   (collision)
  );

  initial begin
    gpu_clk = 1'b0;
    forever #5 gpu_clk = ~gpu_clk;
  end

  always @(posedge gpu_clk) cyc <= cyc + 1;

  // Synchronous tile memory
  initial tile_data = 12'h000;
  always @(posedge gpu_clk) if (tile_rd_en) tile_data <= mem[tile_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply one input cycle, record what the outputs must be, then advance one clock.
  task automatic drive(input logic r, input logic pv, input logic ls, input logic [3:0] m,
                       input logic [63:0] tn, input logic [31:0] xo, input logic [31:0] yo,
                       input logic [11:0] bg);
    int n, cnt, sel, a;
    reset = r; pixel_valid = pv; line_start = ls; match = m;
    tile_number = tn; x_offset = xo; y_offset = yo; bg_color = bg;
    n = cyc; cnt = 0; sel = -1;
    for (int j = 0; j < 4; j++) begin
      if (m[j] && tn[16*j +: 16] != 16'hFFFF) begin
        cnt++;
        if (sel < 0) sel = j;
      end
    end
    if (sel >= 0)
      a = (int'(tn[16*sel +: 16]) % 256) * 256 + (int'(yo[8*sel +: 8]) % 16) * 16
          + (int'(xo[8*sel +: 8]) % 16);
    else
      a = 0;
    if (n + 2 < MAXC) begin
      k_s0[n+1] = 1'b1; k_col[n+2] = 1'b1;
      if (r) begin
        coll_m = 1'b0;
        e_rd[n+1] = 1'b0; e_addr[n+1] = 16'h0000; e_coll[n+1] = 1'b0;
        k_col[n+1] = 1'b1; e_cv[n+1] = 1'b0; e_col[n+1] = 12'h000;
        e_cv[n+2] = 1'b0; e_col[n+2] = 12'h000;
      end else begin
        if (pv && cnt >= 2) coll_m = 1'b1;
        else if (ls) coll_m = 1'b0;
        e_rd[n+1]   = pv && (sel >= 0);
        e_addr[n+1] = 16'(a);
        e_coll[n+1] = coll_m;
        e_cv[n+2]   = pv;
        if (!pv) e_col[n+2] = 12'h000;
        else if (sel >= 0 && mem[a] != 12'h000) e_col[n+2] = mem[a];
        else e_col[n+2] = bg;
      end
    end
    @(posedge gpu_clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'h0, 12'h000);
  endtask

  // Per-cycle comparison against the model's expectation slots
  always @(negedge gpu_clk) begin
    if (cyc < MAXC && k_s0[cyc]) begin
      chk("tile_rd_en", 32'(tile_rd_en), 32'(e_rd[cyc]));
      chk("tile_addr", 32'(tile_addr), 32'(e_addr[cyc]));
      chk("collision", 32'(collision), 32'(e_coll[cyc]));
    end
    if (cyc < MAXC && k_col[cyc]) begin
      chk("color_valid", 32'(color_valid), 32'(e_cv[cyc]));
      chk("color", 32'(color), 32'(e_col[cyc]));
    end
  end

  initial begin
    logic [63:0] tn;
    logic [31:0] xo, yo;
    logic [3:0]  m;
    for (int a = 0; a < 65536; a++)
      mem[a] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
    mem[16'h0573] = 12'hF00;
    mem[16'h0200] = 12'h000;
    reset = 1'b1; pixel_valid = 1'b0; line_start = 1'b0; match = 4'b0000;
    tile_number = 64'hFFFF_FFFF_FFFF_FFFF; x_offset = 32'h0; y_offset = 32'h0; bg_color = 12'h000;
    @(posedge gpu_clk); #1;
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 1'b0, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'h0, 12'h000);
    chk("reset color_valid", 32'(color_valid), 32'h0);
    chk("reset collision", 32'(collision), 32'h0);

    // Single sprite: sprite 2, tile 5, x=3, y=7
    drive(1'b0, 1'b1, 1'b1, 4'b0100, 64'hFFFF_0005_FFFF_FFFF, 32'h0003_0000, 32'h0007_0000, 12'h123);
    chk("single addr", 32'(tile_addr), 32'h0573);
    chk("single rd_en", 32'(tile_rd_en), 32'h1);
    idle();
    chk("single color", 32'(color), 32'h0F00);
    chk("single color_valid", 32'(color_valid), 32'h1);

    // Priority: sprites 1 and 3 (tiles 9, 4)
    drive(1'b0, 1'b1, 1'b0, 4'b1010, 64'h0004_FFFF_0009_FFFF, 32'h0000_0200, 32'h0000_0100, 12'h321);
    chk("priority addr", 32'(tile_addr), 32'h0912);
    chk("priority collision", 32'(collision), 32'h1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'h0, 12'h111);
      chk("collision sticky", 32'(collision), 32'h1);
    end
    drive(1'b0, 1'b1, 1'b1, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'h0, 12'h111);
    chk("collision cleared", 32'(collision), 32'h0);

    // Transparent texel reveals background only
    drive(1'b0, 1'b1, 1'b0, 4'b0011, 64'hFFFF_FFFF_0006_0002, 32'h0, 32'h0, 12'h0AF);
    idle();
    chk("transparent color", 32'(color), 32'h00AF);
    drive(1'b0, 1'b1, 1'b1, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'h0, 12'h000);

    // Disabled tile
    drive(1'b0, 1'b1, 1'b0, 4'b0001, 64'h0001_0002_0003_FFFF, 32'h0, 32'h0, 12'h555);
    chk("disabled rd_en", 32'(tile_rd_en), 32'h0);
    chk("disabled collision", 32'(collision), 32'h0);
    idle();
    chk("disabled color", 32'(color), 32'h0555);

    // Throughput: 20 back-to-back pixels alternating hit/miss
    for (int i = 0; i < 20; i++) begin
      tn = {$urandom, $urandom};
      m  = (i % 2 == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      if (m == 4'b0000) tn = 64'hFFFF_FFFF_FFFF_FFFF;
      else tn = tn & 64'h00FF_00FF_00FF_00FF;
      drive(1'b0, 1'b1, 1'b0, m, tn, $urandom & 32'h0F0F_0F0F, $urandom & 32'h0F0F_0F0F, 12'($urandom));
    end
    idle();
    idle();

    // Reset with two pixels in flight
    drive(1'b0, 1'b1, 1'b0, 4'b0011, 64'hFFFF_FFFF_0010_0020, 32'h0, 32'h0, 12'hABC);
    drive(1'b0, 1'b1, 1'b0, 4'b0011, 64'hFFFF_FFFF_0011_0021, 32'h0, 32'h0, 12'hABD);
    drive(1'b1, 1'b1, 1'b0, 4'b0011, 64'hFFFF_FFFF_0012_0022, 32'h0, 32'h0, 12'hABE);
    chk("reset mid color_valid", 32'(color_valid), 32'h0);
    chk("reset mid color", 32'(color), 32'h0);
    chk("reset mid collision", 32'(collision), 32'h0);
    chk("reset mid rd_en", 32'(tile_rd_en), 32'h0);
    idle();
    chk("no stale color_valid", 32'(color_valid), 32'h0);

    // Line start coincident with a double match
    drive(1'b0, 1'b1, 1'b1, 4'b0011, 64'hFFFF_FFFF_0030_0031, 32'h0, 32'h0, 12'h0F0);
    chk("line_start with overlap", 32'(collision), 32'h1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      for (int j = 0; j < 4; j++)
        tn[16*j +: 16] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      xo = $urandom;
      yo = $urandom;
      m  = 4'($urandom);
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 29) == 0), m, tn, xo, yo, 12'($urandom));
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
